// File: rtl/ods_multilane_drain_if.sv
// Handshake bundle between the drain unit, the accumulator stream and the lanes.
// master drives words in and takes beats out; slave is the drain itself.
interface ods_multilane_drain_if #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int NB_LANES           = 3
);
    logic                              in_valid;
    logic                              in_ready;
    logic [ACCUMULATION_WIDTH-1:0]     in_data;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [NB_LANES*IO_DATA_WIDTH-1:0] out_data;
    logic [NB_LANES-1:0]               out_mask;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_mask
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_mask
    );
endinterface

// File: rtl/ods_multilane_drain.sv
// Output drain: quantise, buffer and pack NB_LANES words per beat onto the lanes.
// Define ODS_ROUND_NEAREST_EN for round-half-away-from-zero instead of floor.
module ods_multilane_drain #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int NB_LANES           = 3,
    parameter int DEPTH              = 16,
    parameter int FRAC_SHIFT         = 0
) (
    input  logic        clk,
    input  logic        arst_n_in,
    ods_multilane_drain_if.slave bus,
    output logic        driving_cons,
    output logic [15:0] sat_count,
    input  logic        clear_stats,
    output logic        busy
);
    localparam int IW = IO_DATA_WIDTH;
    localparam int AW = ACCUMULATION_WIDTH;
    localparam int SW = AW + 1;
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW:0] LANES   = (PW+1)'(NB_LANES);
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic signed [SW-1:0] QMAX = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] QMIN = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};

    typedef enum logic {FILL, FLUSH} state_t;

    state_t state_q, state_nx;

    logic signed [SW-1:0] ext, biased, shifted;
    logic                 sat_hi, sat_lo;
    logic [IW-1:0]        q;

    assign ext = {bus.in_data[AW-1], bus.in_data};

`ifdef ODS_ROUND_NEAREST_EN
    localparam logic [SW-1:0] HALF = ({{(SW-1){1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;
    logic [SW-1:0] bias;
    // Negative inputs take one less so exact halves still round away from zero.
    assign bias   = (bus.in_data[AW-1] && FRAC_SHIFT > 0) ? HALF - 1'b1 : HALF;
    assign biased = ext + bias;
`else
    assign biased = ext;
`endif

    assign shifted = biased >>> FRAC_SHIFT;
    assign sat_hi  = shifted > QMAX;
    assign sat_lo  = shifted < QMIN;
    assign q       = sat_hi ? QMAX[IW-1:0] :
                     sat_lo ? QMIN[IW-1:0] : shifted[IW-1:0];

    logic [IW-1:0] mem [DEPTH];
    logic [PW:0]   wr_q, rd_q, wr_nx, rd_nx;
    logic [PW:0]   cnt, cnt_nx, n_cur, n_nx;
    logic          push, pop, ov_q, ov_nx;
    logic [NB_LANES*IW-1:0] data_q, data_nx;
    logic [NB_LANES-1:0]    mask_q, mask_nx;
    logic [15:0]   sat_q;

    assign cnt    = wr_q - rd_q;
    assign n_cur  = (cnt < LANES) ? cnt : LANES;
    assign push   = bus.in_valid & bus.in_ready;
    assign pop    = ov_q & bus.out_ready;
    assign wr_nx  = wr_q + {{PW{1'b0}}, push};
    assign rd_nx  = rd_q + (pop ? n_cur : '0);
    assign cnt_nx = wr_nx - rd_nx;
    assign n_nx   = (cnt_nx < LANES) ? cnt_nx : LANES;

    assign bus.in_ready = arst_n_in & (cnt < DEPTH_W) & (state_q == FILL);

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            FILL:  if (push && bus.in_last) state_nx = FLUSH;
            FLUSH: if (pop && cnt_nx == '0) state_nx = FILL;
        endcase
    end

    assign ov_nx = (cnt_nx >= LANES) | ((state_nx == FLUSH) & (cnt_nx != '0));

    // Beat is built from next-cycle FIFO state; a word written this edge is forwarded.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        data_nx = '0;
        mask_nx = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            idx = rd_nx[PW-1:0] + PW'(i);
            if (ov_nx && ((PW+1)'(i) < n_nx)) begin
                mask_nx[i] = 1'b1;
                data_nx[i*IW +: IW] = (push && idx == wr_q[PW-1:0]) ? q : mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[PW-1:0]] <= q;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= FILL;
            wr_q    <= '0;
            rd_q    <= '0;
            ov_q    <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_nx;
            wr_q    <= wr_nx;
            rd_q    <= rd_nx;
            ov_q    <= ov_nx;
            data_q  <= data_nx;
            mask_q  <= mask_nx;
            if (clear_stats)
                sat_q <= '0;
            else if (push && (sat_hi || sat_lo) && sat_q != 16'hFFFF)
                sat_q <= sat_q + 16'd1;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_data  = data_q;
    assign bus.out_mask  = mask_q;
    assign driving_cons  = ov_q;
    assign sat_count     = sat_q;
    assign busy          = (cnt != '0) | (state_q == FLUSH);
endmodule

// File: tb/tb_ods_multilane_drain.sv
// Directed bench for ods_multilane_drain: flush, saturation, backpressure,
// shift/rounding, reset mid-flush and a long wrap-around stream.
module tb_ods_multilane_drain;
    localparam int IW = 16;
    localparam int AW = 32;
    localparam int NL = 3;
    localparam int BW = NL + NL*IW;

    logic clk = 1'b0;
    logic arst_n_in;
    always #5 clk = ~clk;

    ods_multilane_drain_if #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL)) bus ();
    ods_multilane_drain_if #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL)) bus2 ();

    logic        driving_cons, clear_stats, busy;
    logic [15:0] sat_count;
    logic        driving_cons2, clear_stats2, busy2;
    logic [15:0] sat_count2;

    ods_multilane_drain #(
        .IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
        .DEPTH(16), .FRAC_SHIFT(0)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .bus(bus),
        .driving_cons(driving_cons), .sat_count(sat_count),
        .clear_stats(clear_stats), .busy(busy)
    );

    ods_multilane_drain #(
        .IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
        .DEPTH(16), .FRAC_SHIFT(4)
    ) dut2 (
        .clk(clk), .arst_n_in(arst_n_in), .bus(bus2),
        .driving_cons(driving_cons2), .sat_count(sat_count2),
        .clear_stats(clear_stats2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    bit pushing_done;
    logic [BW-1:0] beats[$];
    logic [BW-1:0] beats2[$];

    always @(negedge clk) begin
        if (arst_n_in && bus.out_valid && bus.out_ready)
            beats.push_back({bus.out_mask, bus.out_data});
        if (arst_n_in && bus2.out_valid && bus2.out_ready)
            beats2.push_back({bus2.out_mask, bus2.out_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge so no edge passes unchecked.
    task automatic push_word(input logic [AW-1:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                return;
            end
        end
        errors++;
        $display("FAIL push_timeout got no in_ready exp in_ready=1 data=%0h", d);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push_word2(input logic [AW-1:0] d, input logic last);
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        bus2.in_last  = last;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus2.in_ready) begin
                step();
                bus2.in_valid = 1'b0;
                bus2.in_last  = 1'b0;
                return;
            end
        end
        errors++;
        $display("FAIL push2_timeout got no in_ready exp in_ready=1 data=%0h", d);
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int t = 0; t < max_cycles; t++) begin
            @(negedge clk);
            if (!busy) return;
        end
        errors++;
        $display("FAIL idle_timeout got busy=%0b exp 0", busy);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data got %0h exp 0", bus.out_data); end
        checks++; if (bus.out_mask !== '0) begin errors++; $display("FAIL rst_out_mask got %0b exp 0", bus.out_mask); end
        checks++; if (driving_cons !== 1'b0) begin errors++; $display("FAIL rst_driving got %0b exp 0", driving_cons); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_sat got %0d exp 0", sat_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        step();
        arst_n_in = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %0b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_partial_flush();
        logic [BW-1:0] e0, e1;
        e0 = {3'b111, 16'd100, 16'hFFF9, 16'd5};
        e1 = {3'b011, 16'd0, 16'd2, 16'd1};
        step();
        beats.delete();
        bus.out_ready = 1'b1;
        push_word(32'd5, 1'b0);
        push_word(-32'sd7, 1'b0);
        push_word(32'd100, 1'b0);
        push_word(32'd1, 1'b0);
        push_word(32'd2, 1'b1);
        wait_idle(20);
        checks++;
        if (beats.size() != 2) begin
            errors++; $display("FAIL flush_beats got %0d exp 2", beats.size());
        end else begin
            checks++; if (beats[0] !== e0) begin errors++; $display("FAIL flush_beat1 got %0h exp %0h", beats[0], e0); end
            checks++; if (beats[1] !== e1) begin errors++; $display("FAIL flush_beat2 got %0h exp %0h", beats[1], e1); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b exp 0", busy); end
        checks++; if (driving_cons !== 1'b0) begin errors++; $display("FAIL flush_driving got %0b exp 0", driving_cons); end
    endtask

    task automatic test_saturation();
        logic [BW-1:0] e0;
        e0 = {3'b111, 16'h7FFF, 16'h8000, 16'h7FFF};
        step();
        beats.delete();
        push_word(32'd40000, 1'b0);
        push_word(-32'sd40000, 1'b0);
        push_word(32'd32767, 1'b1);
        wait_idle(20);
        checks++;
        if (beats.size() != 1) begin
            errors++; $display("FAIL sat_beats got %0d exp 1", beats.size());
        end else begin
            checks++; if (beats[0] !== e0) begin errors++; $display("FAIL sat_words got %0h exp %0h", beats[0], e0); end
        end
        checks++; if (sat_count !== 16'd2) begin errors++; $display("FAIL sat_count got %0d exp 2", sat_count); end
        step();
        clear_stats = 1'b1;
        push_word(32'd40000, 1'b1);
        clear_stats = 1'b0;
        @(negedge clk);
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL sat_clear got %0d exp 0", sat_count); end
        wait_idle(20);
        step();
        push_word(-32'sd40000, 1'b1);
        wait_idle(20);
        checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL sat_after_clear got %0d exp 1", sat_count); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] e;
        logic [IW*NL-1:0] hold;
        hold = {16'd3, 16'd2, 16'd1};
        step();
        beats.delete();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push_word(32'(i), 1'b0);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", bus.in_ready); end
        checks++; if (bus.out_mask !== 3'b111) begin errors++; $display("FAIL bp_mask got %0b exp 111", bus.out_mask); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== hold) begin
                errors++; $display("FAIL bp_hold c=%0d got v=%0b d=%0h exp v=1 d=%0h", c, bus.out_valid, bus.out_data, hold);
            end
        end
        step();
        bus.out_ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        checks++; if (beats.size() != 5) begin errors++; $display("FAIL bp_beats_before_last got %0d exp 5", beats.size()); end
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_residue got v=%0b busy=%0b exp v=0 busy=1", bus.out_valid, busy); end
        step();
        push_word(32'd17, 1'b1);
        wait_idle(20);
        checks++;
        if (beats.size() != 6) begin
            errors++; $display("FAIL bp_beats got %0d exp 6", beats.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (k < 5) e = {3'b111, 16'(3*k+3), 16'(3*k+2), 16'(3*k+1)};
                else       e = {3'b011, 16'd0, 16'd17, 16'd16};
                checks++;
                if (beats[k] !== e) begin errors++; $display("FAIL bp_beat%0d got %0h exp %0h", k, beats[k], e); end
            end
        end
    endtask

    task automatic test_shift();
        logic [IW-1:0] exp_neg;
`ifdef ODS_ROUND_NEAREST_EN
        exp_neg = 16'hFFFE;
`else
        exp_neg = 16'hFFFD;
`endif
        step();
        beats2.delete();
        bus2.out_ready = 1'b1;
        push_word2(32'd37, 1'b0);
        push_word2(-32'sd37, 1'b1);
        for (int t = 0; t < 20 && busy2; t++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (beats2.size() != 1) begin
            errors++; $display("FAIL shift_beats got %0d exp 1", beats2.size());
        end else begin
            checks++; if (beats2[0][15:0] !== 16'd2) begin errors++; $display("FAIL shift_pos got %0h exp 2", beats2[0][15:0]); end
            checks++; if (beats2[0][31:16] !== exp_neg) begin errors++; $display("FAIL shift_neg got %0h exp %0h", beats2[0][31:16], exp_neg); end
            checks++; if (beats2[0][BW-1:NL*IW] !== 3'b011) begin errors++; $display("FAIL shift_mask got %0b exp 011", beats2[0][BW-1:NL*IW]); end
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [BW-1:0] e;
        e = {3'b001, 16'd0, 16'd0, 16'd7};
        step();
        beats.delete();
        bus.out_ready = 1'b0;
        push_word(32'd10, 1'b0);
        push_word(32'd20, 1'b0);
        push_word(32'd30, 1'b0);
        push_word(32'd40, 1'b1);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_flush_state got busy=%0b v=%0b rdy=%0b exp 1 1 0", busy, bus.out_valid, bus.in_ready); end
        #2 arst_n_in = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (driving_cons !== 1'b0) begin errors++; $display("FAIL mrst_driving got %0b exp 0", driving_cons); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %0b exp 0", busy); end
        checks++; if (bus.out_mask !== '0) begin errors++; $display("FAIL mrst_mask got %0b exp 0", bus.out_mask); end
        step();
        arst_n_in = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready got %0b exp 1", bus.in_ready); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL mrst_sat got %0d exp 0", sat_count); end
        step();
        bus.out_ready = 1'b1;
        push_word(32'd7, 1'b1);
        wait_idle(20);
        checks++;
        if (beats.size() != 1) begin
            errors++; $display("FAIL mrst_beats got %0d exp 1", beats.size());
        end else begin
            checks++; if (beats[0] !== e) begin errors++; $display("FAIL mrst_beat got %0h exp %0h", beats[0], e); end
        end
    endtask

    task automatic test_wrap();
        int got[$];
        int bad, first_bad;
        logic signed [IW-1:0] w;
        step();
        beats.delete();
        pushing_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) push_word(32'(i*7 - 3000), i == 999);
                pushing_done = 1'b1;
            end
            begin
                while (!pushing_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_idle(3000);
        foreach (beats[k])
            for (int l = 0; l < NL; l++)
                if (beats[k][NL*IW + l]) begin
                    w = beats[k][l*IW +: IW];
                    got.push_back(int'(w));
                end
        checks++; if (got.size() != 1000) begin errors++; $display("FAIL wrap_count got %0d exp 1000", got.size()); end
        bad = 0;
        first_bad = -1;
        foreach (got[i])
            if (got[i] != i*7 - 3000) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order got %0d wrong words (first idx %0d) exp 0", bad, first_bad); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL wrap_sat got %0d exp 0", sat_count); end
    endtask

    initial begin
        arst_n_in      = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.in_last   = 1'b0;
        bus2.out_ready = 1'b0;
        clear_stats    = 1'b0;
        clear_stats2   = 1'b0;
        #1 arst_n_in = 1'b0;
        test_reset();
        test_partial_flush();
        test_saturation();
        test_backpressure();
        test_shift();
        test_reset_mid_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
